free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter P_ADDR_WIDTH, default 7, physical register ID width.
REQ-002 SHALL have parameter L_ADDR_WIDTH, default 5, architectural register address width.
REQ-003 SHALL have parameter C_NUM, default 4, number of checkpoint slots.
REQ-004 SHALL have parameter INSTR_COUNT, default 2, allocations/releases per cycle.
REQ-005 SHALL define localparam FL_SIZE = 2**P_ADDR_WIDTH - 2**L_ADDR_WIDTH (96 by default).
REQ-006 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have alloc_en  input  [INSTR_COUNT]  per-slot allocation request.
REQ-009 SHALL have alloc_data  output  [INSTR_COUNT][P_ADDR_WIDTH]  allocated physical IDs.
REQ-010 SHALL have alloc_ready  output  1  high when free_count >= INSTR_COUNT.
REQ-011 SHALL have release_en  input  [INSTR_COUNT]  per-slot release at commit.
REQ-012 SHALL have release_data  input  [INSTR_COUNT][P_ADDR_WIDTH]  IDs being returned.
REQ-013 SHALL have take_checkpoint  input  1  save the allocation pointer.
REQ-014 SHALL have instr_to_checkpoint  input  [INSTR_COUNT]  one-hot slot that carries the checkpoint.
REQ-015 SHALL have restore_checkpoint  input  1  roll the allocation pointer back.
REQ-016 SHALL have new_checkpoint  input  [$clog2(C_NUM)]  slot to restore.
REQ-017 SHALL have free_count  output  [$clog2(FL_SIZE+1)]  number of free IDs.
REQ-018 SHALL have overflow_err  output  1  sticky flag, release into a full list.

Function
REQ-019 SHALL store IDs in a circular buffer of FL_SIZE entries with head/tail indices 0..FL_SIZE-1 plus one wrap bit each; wrap bit toggles when an index passes FL_SIZE-1 to 0.
REQ-020 SHALL compute free_count combinationally: tail_idx-head_idx when wrap bits are equal, else FL_SIZE-head_idx+tail_idx.
REQ-021 SHALL drive alloc_data combinationally (zero-latency): slot i gets entry (head + k) mod FL_SIZE, where k = number of set alloc_en bits below i; alloc_data of slots with alloc_en low is don't-care.
REQ-022 SHALL advance head by popcount(alloc_en) on a clock edge only when alloc_ready is high and restore_checkpoint is low; alloc_en while alloc_ready is low SHALL be ignored.
REQ-023 SHALL write each set release_en slot into tail in slot order and advance tail by popcount(release_en), every cycle, including restore cycles.
REQ-024 SHALL, when a release would make free_count exceed FL_SIZE, drop that release and set overflow_err.
REQ-025 SHALL keep an internal checkpoint pointer ckpt_ptr; on take_checkpoint (restore low) save to slot ckpt_ptr the head after advancing only by allocations in slots below the set bit of instr_to_checkpoint and including that slot, then ckpt_ptr <= ckpt_ptr+1 (wraps mod C_NUM).
REQ-026 SHALL, on restore_checkpoint, set head <= saved head[new_checkpoint], ckpt_ptr <= new_checkpoint+1, and ignore alloc_en and take_checkpoint that cycle.
REQ-027 SHALL handle simultaneous allocation and release in one cycle, both pointers moving independently.
REQ-028 SHALL not validate release_data values; duplicate or architectural IDs are the caller's responsibility.

Reset
REQ-029 SHALL on rst_n low asynchronously: buffer entry j <= 2**L_ADDR_WIDTH + j, head = 0/wrap 0, tail = 0/wrap 1, ckpt_ptr = 0, overflow_err = 0.
REQ-030 SHALL after reset present free_count = FL_SIZE (96), alloc_ready = 1, alloc_data = {33,32} for alloc_en = 2'b11.
REQ-031 SHALL leave checkpoint slot contents undefined after reset; restoring an unwritten slot is illegal.
REQ-032 SHALL return to reset state if rst_n asserts mid-operation, discarding pending allocations.

Verification
REQ-033 Reset, alloc_en=11 for 1 cycle -> alloc_data={33,32}, next cycle free_count=94, alloc_data={35,34}.
REQ-034 alloc_en=10 after reset -> alloc_data[1]=32, next free_count=95.
REQ-035 Drain to free_count=1 -> alloc_ready=0, alloc_en=11 ignored, count stays 1; release_en=01 id 40 -> count 2, ready=1.
REQ-036 Reset, take_checkpoint with instr_to_checkpoint=01, alloc_en=11 -> slot 0 saves head=1; alloc 4 more; restore new_checkpoint=0 -> head=1, free_count=95, alloc_data[0]=33.
REQ-037 Restore with release_en=11 same cycle -> head restored, tail +2, free_count reflects both.
REQ-038 Reset, release_en=01 with no allocation -> overflow_err=1, free_count stays 96, overflow_err holds until reset.

Source files
------------

// File: rtl/free_list.sv
// Physical register free list: circular buffer of free IDs with multi-slot
// zero-latency allocation, in-order release, and checkpointed head rollback.

module free_list_lane #(
  parameter int FL_SIZE = 96,
  parameter int IDX_W   = 7,
  parameter int OFS_W   = 2
) (
  input  logic [IDX_W-1:0] hd_idx_i,
  input  logic [OFS_W-1:0] rd_ofs_i,
  input  logic [IDX_W-1:0] tl_idx_i,
  input  logic [OFS_W-1:0] wr_ofs_i,
  output logic [IDX_W-1:0] rd_idx_o,
  output logic [IDX_W-1:0] wr_idx_o
);
  localparam int W = IDX_W + 1;

  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] b,
                                               input logic [OFS_W-1:0] o);
    logic [W-1:0] s;
    s = W'(b) + W'(o);
    if (s >= W'(FL_SIZE)) s = s - W'(FL_SIZE);
    return s[IDX_W-1:0];
  endfunction

  assign rd_idx_o = mod_add(hd_idx_i, rd_ofs_i);
  assign wr_idx_o = mod_add(tl_idx_i, wr_ofs_i);
endmodule

module free_list #(
  parameter int P_ADDR_WIDTH = 7,
  parameter int L_ADDR_WIDTH = 5,
  parameter int C_NUM        = 4,
  parameter int INSTR_COUNT  = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [INSTR_COUNT-1:0]                         alloc_en,
  output logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0]       alloc_data,
  output logic                                           alloc_ready,
  input  logic [INSTR_COUNT-1:0]                         release_en,
  input  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0]       release_data,
  input  logic                                           take_checkpoint,
  input  logic [INSTR_COUNT-1:0]                         instr_to_checkpoint,
  input  logic                                           restore_checkpoint,
  input  logic [$clog2(C_NUM)-1:0]                       new_checkpoint,
  output logic [$clog2(2**P_ADDR_WIDTH-2**L_ADDR_WIDTH+1)-1:0] free_count,
  output logic                                           overflow_err
);
  localparam int FL_SIZE = 2**P_ADDR_WIDTH - 2**L_ADDR_WIDTH;
  localparam int IDX_W   = $clog2(FL_SIZE);
  localparam int CNT_W   = $clog2(FL_SIZE + 1);
  localparam int OFS_W   = $clog2(INSTR_COUNT + 1);
  localparam int CK_W    = $clog2(C_NUM);
  localparam int W       = CNT_W + 1;

  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  logic [FL_SIZE-1:0][P_ADDR_WIDTH-1:0] buf_q;
  ptr_t                                 head_q, head_d, tail_q, tail_d, ck_head;
  ptr_t [C_NUM-1:0]                     ckpt_q;
  logic [CK_W-1:0]                      ckpt_ptr_q, ckpt_ptr_d;
  logic                                 ovf_q;

  logic [W-1:0]                         cnt_w;
  logic                                 alloc_go, ck_go, ovf_set, ck_seen;
  logic [OFS_W-1:0]                     rd_acc, wr_acc, ck_cnt, n_alloc;
  logic [INSTR_COUNT-1:0][OFS_W-1:0]    rd_ofs, wr_ofs;
  logic [INSTR_COUNT-1:0][IDX_W-1:0]    rd_idx, wr_idx;
  logic [INSTR_COUNT-1:0]               wr_en, ck_mask;

  function automatic ptr_t ptr_adv(input ptr_t p, input logic [OFS_W-1:0] n);
    logic [W-1:0] s;
    ptr_t         r;
    r = p;
    s = W'(p.idx) + W'(n);
    if (s >= W'(FL_SIZE)) begin
      s      = s - W'(FL_SIZE);
      r.wrap = ~p.wrap;
    end
    r.idx = s[IDX_W-1:0];
    return r;
  endfunction

  function automatic logic [CK_W-1:0] ck_inc(input logic [CK_W-1:0] c);
    return (c == CK_W'(C_NUM - 1)) ? '0 : c + CK_W'(1);
  endfunction

  // Equal wrap bits mean tail has not lapped head; otherwise it is one lap ahead.
  assign cnt_w        = (head_q.wrap == tail_q.wrap)
                      ? W'(tail_q.idx) - W'(head_q.idx)
                      : W'(FL_SIZE) - W'(head_q.idx) + W'(tail_q.idx);
  assign free_count   = cnt_w[CNT_W-1:0];
  assign alloc_ready  = (cnt_w >= W'(INSTR_COUNT));
  assign overflow_err = ovf_q;

  always_comb begin
    alloc_go = alloc_ready & ~restore_checkpoint;
    ck_go    = take_checkpoint & ~restore_checkpoint;
    rd_acc   = '0;
    wr_acc   = '0;
    ck_cnt   = '0;
    ck_seen  = 1'b0;
    ovf_set  = 1'b0;
    rd_ofs   = '0;
    wr_ofs   = '0;
    wr_en    = '0;
    ck_mask  = '0;
    for (int i = 0; i < INSTR_COUNT; i++) begin
      rd_ofs[i] = rd_acc;
      if (alloc_en[i]) rd_acc = rd_acc + OFS_W'(1);
      wr_ofs[i] = wr_acc;
      if (release_en[i]) begin
        // A release into an already-full list would overwrite a live entry.
        if (cnt_w + W'(wr_acc) >= W'(FL_SIZE)) ovf_set = 1'b1;
        else begin
          wr_en[i] = 1'b1;
          wr_acc   = wr_acc + OFS_W'(1);
        end
      end
    end
    for (int i = INSTR_COUNT - 1; i >= 0; i--) begin
      ck_seen    = ck_seen | instr_to_checkpoint[i];
      ck_mask[i] = ck_seen;
    end
    for (int i = 0; i < INSTR_COUNT; i++)
      if (alloc_go && alloc_en[i] && ck_mask[i]) ck_cnt = ck_cnt + OFS_W'(1);
    n_alloc    = alloc_go ? rd_acc : '0;
    ck_head    = ptr_adv(head_q, ck_cnt);
    head_d     = restore_checkpoint ? ckpt_q[new_checkpoint] : ptr_adv(head_q, n_alloc);
    tail_d     = ptr_adv(tail_q, wr_acc);
    ckpt_ptr_d = restore_checkpoint ? ck_inc(new_checkpoint)
               : ck_go              ? ck_inc(ckpt_ptr_q) : ckpt_ptr_q;
  end

  for (genvar g = 0; g < INSTR_COUNT; g++) begin : g_lane
    free_list_lane #(.FL_SIZE(FL_SIZE), .IDX_W(IDX_W), .OFS_W(OFS_W)) u_lane (
      .hd_idx_i (head_q.idx),
      .rd_ofs_i (rd_ofs[g]),
      .tl_idx_i (tail_q.idx),
      .wr_ofs_i (wr_ofs[g]),
      .rd_idx_o (rd_idx[g]),
      .wr_idx_o (wr_idx[g])
    );
    assign alloc_data[g] = buf_q[rd_idx[g]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < FL_SIZE; j++) buf_q[j] <= P_ADDR_WIDTH'(2**L_ADDR_WIDTH + j);
      head_q     <= '{wrap: 1'b0, idx: '0};
      tail_q     <= '{wrap: 1'b1, idx: '0};
      ckpt_ptr_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      for (int i = 0; i < INSTR_COUNT; i++)
        if (wr_en[i]) buf_q[wr_idx[i]] <= release_data[i];
      head_q     <= head_d;
      tail_q     <= tail_d;
      ckpt_ptr_q <= ckpt_ptr_d;
      ovf_q      <= ovf_q | ovf_set;
    end
  end

  // Checkpoint slots carry no reset value; restoring an unwritten slot is illegal.
  always_ff @(posedge clk) begin
    if (ck_go) ckpt_q[ckpt_ptr_q] <= ck_head;
  end
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation, drain, checkpoint/restore,
// concurrent release and overflow, with hand-computed expectations.

module tb_free_list;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      alloc_en = '0;
  logic [1:0][6:0] alloc_data;
  logic            alloc_ready;
  logic [1:0]      release_en = '0;
  logic [1:0][6:0] release_data = '0;
  logic            take_checkpoint = 1'b0;
  logic [1:0]      instr_to_checkpoint = '0;
  logic            restore_checkpoint = 1'b0;
  logic [1:0]      new_checkpoint = '0;
  logic [6:0]      free_count;
  logic            overflow_err;
  int              pass_cnt = 0;
  int              total_cnt = 0;

  free_list dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alloc_en            (alloc_en),
    .alloc_data          (alloc_data),
    .alloc_ready         (alloc_ready),
    .release_en          (release_en),
    .release_data        (release_data),
    .take_checkpoint     (take_checkpoint),
    .instr_to_checkpoint (instr_to_checkpoint),
    .restore_checkpoint  (restore_checkpoint),
    .new_checkpoint      (new_checkpoint),
    .free_count          (free_count),
    .overflow_err        (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_en = '0; release_en = '0; release_data = '0;
    take_checkpoint = 1'b0; instr_to_checkpoint = '0;
    restore_checkpoint = 1'b0; new_checkpoint = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    alloc_en = 2'b11; tick(); tick();
    rst_n = 1'b0; #2;
    total_cnt++; if (free_count !== 7'd96) $display("FAIL rst_count got %0d want 96", free_count); else pass_cnt++;
    total_cnt++; if (alloc_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", alloc_ready); else pass_cnt++;
    total_cnt++; if (overflow_err !== 1'b0) $display("FAIL rst_ovf got %0b want 0", overflow_err); else pass_cnt++;
    total_cnt++; if (alloc_data[0] !== 7'd32 || alloc_data[1] !== 7'd33)
      $display("FAIL rst_data got {%0d,%0d} want {33,32}", alloc_data[1], alloc_data[0]); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; clear_inputs(); tick();
  endtask

  task automatic test_alloc_pair();
    do_reset();
    alloc_en = 2'b11; #1;
    total_cnt++; if (alloc_data[0] !== 7'd32 || alloc_data[1] !== 7'd33)
      $display("FAIL pair_data0 got {%0d,%0d} want {33,32}", alloc_data[1], alloc_data[0]); else pass_cnt++;
    tick();
    total_cnt++; if (free_count !== 7'd94) $display("FAIL pair_count got %0d want 94", free_count); else pass_cnt++;
    total_cnt++; if (alloc_data[0] !== 7'd34 || alloc_data[1] !== 7'd35)
      $display("FAIL pair_data1 got {%0d,%0d} want {35,34}", alloc_data[1], alloc_data[0]); else pass_cnt++;
    alloc_en = 2'b00;
  endtask

  task automatic test_alloc_single();
    do_reset();
    alloc_en = 2'b10; #1;
    total_cnt++; if (alloc_data[1] !== 7'd32) $display("FAIL single_data got %0d want 32", alloc_data[1]); else pass_cnt++;
    tick(); alloc_en = 2'b00; #1;
    total_cnt++; if (free_count !== 7'd95) $display("FAIL single_count got %0d want 95", free_count); else pass_cnt++;
  endtask

  task automatic test_drain();
    do_reset();
    alloc_en = 2'b11;
    repeat (47) tick();
    total_cnt++; if (free_count !== 7'd2 || alloc_ready !== 1'b1)
      $display("FAIL drain_two got cnt=%0d rdy=%0b want 2/1", free_count, alloc_ready); else pass_cnt++;
    alloc_en = 2'b01; tick();
    total_cnt++; if (free_count !== 7'd1 || alloc_ready !== 1'b0)
      $display("FAIL drain_one got cnt=%0d rdy=%0b want 1/0", free_count, alloc_ready); else pass_cnt++;
    alloc_en = 2'b11; #1;
    total_cnt++; if (alloc_data[0] !== 7'd127) $display("FAIL drain_last got %0d want 127", alloc_data[0]); else pass_cnt++;
    tick();
    total_cnt++; if (free_count !== 7'd1) $display("FAIL drain_ignored got %0d want 1", free_count); else pass_cnt++;
    alloc_en = 2'b00; release_en = 2'b01; release_data[0] = 7'd40; tick();
    release_en = 2'b00; #1;
    total_cnt++; if (free_count !== 7'd2 || alloc_ready !== 1'b1)
      $display("FAIL drain_release got cnt=%0d rdy=%0b want 2/1", free_count, alloc_ready); else pass_cnt++;
    alloc_en = 2'b11; #1;
    total_cnt++; if (alloc_data[0] !== 7'd127 || alloc_data[1] !== 7'd40)
      $display("FAIL drain_wrap got {%0d,%0d} want {40,127}", alloc_data[1], alloc_data[0]); else pass_cnt++;
    tick(); alloc_en = 2'b00; #1;
    total_cnt++; if (free_count !== 7'd0 || alloc_ready !== 1'b0)
      $display("FAIL drain_empty got cnt=%0d rdy=%0b want 0/0", free_count, alloc_ready); else pass_cnt++;
  endtask

  task automatic test_checkpoint();
    do_reset();
    take_checkpoint = 1'b1; instr_to_checkpoint = 2'b01; alloc_en = 2'b11; tick();
    take_checkpoint = 1'b0; tick(); tick();
    total_cnt++; if (free_count !== 7'd90) $display("FAIL ckpt_pre got %0d want 90", free_count); else pass_cnt++;
    restore_checkpoint = 1'b1; new_checkpoint = 2'd0; take_checkpoint = 1'b1; tick();
    restore_checkpoint = 1'b0; take_checkpoint = 1'b0; alloc_en = 2'b01; #1;
    total_cnt++; if (free_count !== 7'd95) $display("FAIL ckpt_restore_cnt got %0d want 95", free_count); else pass_cnt++;
    total_cnt++; if (alloc_data[0] !== 7'd33) $display("FAIL ckpt_restore_data got %0d want 33", alloc_data[0]); else pass_cnt++;
    take_checkpoint = 1'b1; instr_to_checkpoint = 2'b10; alloc_en = 2'b11; tick();
    take_checkpoint = 1'b0; tick();
    alloc_en = 2'b00; restore_checkpoint = 1'b1; new_checkpoint = 2'd1; tick();
    restore_checkpoint = 1'b0; alloc_en = 2'b01; #1;
    total_cnt++; if (free_count !== 7'd93) $display("FAIL ckpt_slot1_cnt got %0d want 93", free_count); else pass_cnt++;
    total_cnt++; if (alloc_data[0] !== 7'd35) $display("FAIL ckpt_slot1_data got %0d want 35", alloc_data[0]); else pass_cnt++;
  endtask

  // Continues from the state left by test_checkpoint (head=3, tail=0 lapped).
  task automatic test_restore_release();
    alloc_en = 2'b11; tick();
    total_cnt++; if (free_count !== 7'd91) $display("FAIL rr_pre got %0d want 91", free_count); else pass_cnt++;
    restore_checkpoint = 1'b1; new_checkpoint = 2'd1;
    release_en = 2'b11; release_data[0] = 7'd50; release_data[1] = 7'd51; tick();
    clear_inputs(); alloc_en = 2'b01; #1;
    total_cnt++; if (free_count !== 7'd95) $display("FAIL rr_count got %0d want 95", free_count); else pass_cnt++;
    total_cnt++; if (alloc_data[0] !== 7'd35) $display("FAIL rr_data got %0d want 35", alloc_data[0]); else pass_cnt++;
    alloc_en = 2'b00;
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_en = 2'b11; tick();
    release_en = 2'b01; release_data[0] = 7'd70; tick();
    total_cnt++; if (free_count !== 7'd93) $display("FAIL b2b_one got %0d want 93", free_count); else pass_cnt++;
    release_en = 2'b11; release_data[1] = 7'd71; tick();
    clear_inputs(); #1;
    total_cnt++; if (free_count !== 7'd93) $display("FAIL b2b_two got %0d want 93", free_count); else pass_cnt++;
    total_cnt++; if (overflow_err !== 1'b0) $display("FAIL b2b_ovf got %0b want 0", overflow_err); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    release_en = 2'b01; release_data[0] = 7'd5; tick();
    release_en = 2'b00; alloc_en = 2'b01; #1;
    total_cnt++; if (overflow_err !== 1'b1) $display("FAIL ovf_set got %0b want 1", overflow_err); else pass_cnt++;
    total_cnt++; if (free_count !== 7'd96) $display("FAIL ovf_count got %0d want 96", free_count); else pass_cnt++;
    total_cnt++; if (alloc_data[0] !== 7'd32) $display("FAIL ovf_dropped got %0d want 32", alloc_data[0]); else pass_cnt++;
    alloc_en = 2'b00; tick(); tick();
    alloc_en = 2'b11; tick(); alloc_en = 2'b00; #1;
    total_cnt++; if (overflow_err !== 1'b1 || free_count !== 7'd94)
      $display("FAIL ovf_sticky got ovf=%0b cnt=%0d want 1/94", overflow_err, free_count); else pass_cnt++;
    do_reset();
    total_cnt++; if (overflow_err !== 1'b0) $display("FAIL ovf_clear got %0b want 0", overflow_err); else pass_cnt++;
    alloc_en = 2'b01; tick();
    alloc_en = 2'b00; release_en = 2'b11; release_data[0] = 7'd60; release_data[1] = 7'd61; tick();
    release_en = 2'b00; #1;
    total_cnt++; if (free_count !== 7'd96 || overflow_err !== 1'b1)
      $display("FAIL ovf_partial got cnt=%0d ovf=%0b want 96/1", free_count, overflow_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alloc_pair();
    test_alloc_single();
    test_drain();
    test_checkpoint();
    test_restore_release();
    test_back_to_back();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
